oflow_value_not_valid: RTL and testbench

Dual-clock (asynchronous) FIFO with Gray-coded pointers, carrying WIDTH-bit words from a writer in the wclk domain to a reader in the rclk domain. It sits on clock-domain boundaries and provides full/empty/overflow/underflow flags on both sides. The read port is show-ahead: the head word is presented combinationally whenever the FIFO is not empty.

---
 rtl/oflow_value_not_valid_pkg.sv | 12 +
 rtl/oflow_value_not_valid_gray_cnt.sv | 39 +++
 rtl/oflow_value_not_valid.sv | 123 ++++++++++++
 tb/tb_oflow_value_not_valid.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/oflow_value_not_valid_pkg.sv
// rtl/oflow_value_not_valid_pkg.sv - overflow policy names and Gray encoding for the dual-clock FIFO
package oflow_value_not_valid_pkg;

  localparam string OFLOW_REPLACE = "REPLACE";
  localparam string OFLOW_IGNORE  = "IGNORE";

  // Callers cast to and from their own pointer width.
  function automatic logic [31:0] gray_enc(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/oflow_value_not_valid_gray_cnt.sv
// rtl/oflow_value_not_valid_gray_cnt.sv - binary pointer with Gray-coded current/next/previous views
module gray_cnt
  import oflow_value_not_valid_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  output logic [DEPTH-1:0] cnt,
  output logic [DEPTH-1:0] cnt_next,
  output logic [DEPTH-1:0] cnt_prev
);

  logic [DEPTH-1:0] cur_q;
  logic [DEPTH-1:0] cur_d;
  logic [DEPTH-1:0] next_b;
  logic [DEPTH-1:0] prev_b;

  always_comb begin
    next_b = cur_q + DEPTH'(1);
    prev_b = cur_q - DEPTH'(1);
    cur_d  = cur_q;
    if (rst) begin
      cur_d = '0;
    end else if (tick) begin
      cur_d = next_b;
    end
  end

  always_ff @(posedge clk) begin
    cur_q <= cur_d;
  end

  assign cnt      = DEPTH'(gray_enc(32'(cur_q)));
  assign cnt_next = DEPTH'(gray_enc(32'(next_b)));
  assign cnt_prev = DEPTH'(gray_enc(32'(prev_b)));

endmodule

// File: rtl/oflow_value_not_valid.sv
// rtl/oflow_value_not_valid.sv - dual-clock FIFO with Gray pointers and show-ahead read port
// Optional write trace: define OFLOW_VALUE_NOT_VALID_TRACE_EN.
module oflow_value_not_valid
  import oflow_value_not_valid_pkg::*;
#(
  parameter int    WIDTH = 8,
  parameter int    DEPTH = 4,
  parameter string OFLOW = "REPLACE"
) (
  input  logic             wclk,
  input  logic             wreset,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wstore,
  output logic             wempty,
  output logic             wfull,
  output logic             woverflow,
  input  logic             rclk,
  input  logic             rread,
  output logic [WIDTH-1:0] rdata,
  output logic             rempty,
  output logic             rfull,
  output logic             runderflow
);

  localparam int NELEM        = 1 << DEPTH;
  localparam bit REPLACE_MODE = (OFLOW == OFLOW_REPLACE);

  if ((OFLOW != OFLOW_REPLACE) && (OFLOW != OFLOW_IGNORE)) begin : g_bad_oflow
    $error("OFLOW must be REPLACE or IGNORE");
  end

  logic             wrst_q, wrst_d;
  logic             rrst_q, rrst_d;
  logic [DEPTH-1:0] wpos, wnext, wprev_unused;
  logic [DEPTH-1:0] rpos, rprev, rnext_unused;
  logic [DEPTH-1:0] rwpos_q, rwpos_d;
  logic [DEPTH-1:0] wrpos_q, wrpos_d;
  logic             wtick, rtick;
  logic             mem_we;
  logic [WIDTH-1:0] mem_q [NELEM];

  // Each domain resets from its own registered copy of wreset.
  always_comb begin
    wrst_d = wreset;
    rrst_d = wreset;
  end

  always_ff @(posedge wclk) begin
    wrst_q <= wrst_d;
  end

  always_ff @(posedge rclk) begin
    rrst_q <= rrst_d;
  end

  assign wtick = wstore & ~wfull;
  assign rtick = rread & ~rempty;

  gray_cnt #(.DEPTH(DEPTH)) u_wcnt (
    .clk      (wclk),
    .rst      (wrst_q),
    .tick     (wtick),
    .cnt      (wpos),
    .cnt_next (wnext),
    .cnt_prev (wprev_unused)
  );

  gray_cnt #(.DEPTH(DEPTH)) u_rcnt (
    .clk      (rclk),
    .rst      (rrst_q),
    .tick     (rtick),
    .cnt      (rpos),
    .cnt_next (rnext_unused),
    .cnt_prev (rprev)
  );

  // Single-stage pointer crossing; Gray coding keeps each sample within one step.
  always_comb begin
    rwpos_d = wrst_q ? '0 : rpos;
    wrpos_d = rrst_q ? '0 : wpos;
  end

  always_ff @(posedge wclk) begin
    rwpos_q <= rwpos_d;
  end

  always_ff @(posedge rclk) begin
    wrpos_q <= wrpos_d;
  end

  assign wempty     = (rwpos_q == wpos);
  assign wfull      = (rwpos_q == wnext);
  assign woverflow  = wfull & wstore;
  assign rempty     = (rpos == wrpos_q);
  assign rfull      = (wrpos_q == rprev);
  assign runderflow = rempty & rread;

  // REPLACE keeps writing the slot at wpos while full, so the last overflow word wins.
  always_comb begin
    mem_we = wstore;
    if (!REPLACE_MODE) begin
      mem_we = wstore & ~wfull;
    end
  end

  always_ff @(posedge wclk) begin
    if (mem_we) begin
      mem_q[wpos] <= wdata;
    end
  end

  assign rdata = mem_q[rpos];

`ifdef OFLOW_VALUE_NOT_VALID_TRACE_EN
  always @(posedge wclk) begin
    if (mem_we) begin
      $display("# store buffer[%0d] = %h", wpos, wdata);
    end
  end
`else
`endif

endmodule

// File: tb/tb_oflow_value_not_valid.sv
// tb/tb_oflow_value_not_valid.sv - directed bench for the dual-clock FIFO, wclk three times rclk
module tb_oflow_value_not_valid;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             wclk   = 1'b0;
  logic             rclk   = 1'b0;
  logic             wreset = 1'b1;
  logic             wstore = 1'b0;
  logic             rread  = 1'b0;
  logic [WIDTH-1:0] wdata  = '0;
  logic             wempty, wfull, woverflow;
  logic             rempty, rfull, runderflow;
  logic [WIDTH-1:0] rdata;

  int checks   = 0;
  int failures = 0;
  int sent     = 0;
  int got_n    = 0;
  logic [7:0] exp_b;

  oflow_value_not_valid #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .OFLOW ("REPLACE")
  ) dut (
    .wclk       (wclk),
    .wreset     (wreset),
    .wdata      (wdata),
    .wstore     (wstore),
    .wempty     (wempty),
    .wfull      (wfull),
    .woverflow  (woverflow),
    .rclk       (rclk),
    .rread      (rread),
    .rdata      (rdata),
    .rempty     (rempty),
    .rfull      (rfull),
    .runderflow (runderflow)
  );

  always #5 wclk = ~wclk;

  initial begin
    #3;
    forever #15 rclk = ~rclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge wclk);
    wdata  = d;
    wstore = 1'b1;
    @(negedge wclk);
    wstore = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    @(negedge rclk);
    while (rempty && n < 10) begin
      @(negedge rclk);
      n++;
    end
    check_eq({tag, "_rempty"}, 32'(rempty), 32'd0);
    check_eq(tag, 32'(rdata), 32'(exp));
    rread = 1'b1;
    @(negedge rclk);
    rread = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge wclk);
    wreset = 1'b1;
    wstore = 1'b0;
    rread  = 1'b0;
    repeat (4) @(negedge rclk);
    @(negedge wclk);
    wreset = 1'b0;
    repeat (3) @(negedge rclk);
    repeat (2) @(negedge wclk);
  endtask

  initial begin
    int n;

    reset_dut();
    check_eq("rst_wempty",     32'(wempty),     32'd1);
    check_eq("rst_rempty",     32'(rempty),     32'd1);
    check_eq("rst_wfull",      32'(wfull),      32'd0);
    check_eq("rst_rfull",      32'(rfull),      32'd0);
    check_eq("rst_woverflow",  32'(woverflow),  32'd0);
    check_eq("rst_runderflow", 32'(runderflow), 32'd0);

    // Three words in order, with crossing latency on the first one
    push(8'hA1);
    check_eq("push_wempty", 32'(wempty), 32'd0);
    @(negedge rclk);
    if (rempty) @(negedge rclk);
    check_eq("first_rempty", 32'(rempty), 32'd0);
    push(8'hB2);
    push(8'hC3);
    pop_check("pop_a1", 8'hA1);
    pop_check("pop_b2", 8'hB2);
    pop_check("pop_c3", 8'hC3);
    check_eq("drain_rempty", 32'(rempty), 32'd1);
    repeat (3) @(negedge wclk);
    check_eq("drain_wempty", 32'(wempty), 32'd1);

    // Underflow leaves the read pointer alone
    @(negedge rclk);
    rread = 1'b1;
    #1;
    check_eq("uflow_flag",   32'(runderflow), 32'd1);
    @(negedge rclk);
    rread = 1'b0;
    #1;
    check_eq("uflow_clear",  32'(runderflow), 32'd0);
    check_eq("uflow_rempty", 32'(rempty),     32'd1);
    push(8'h5A);
    pop_check("uflow_next", 8'h5A);
    repeat (3) @(negedge wclk);

    // Fill to capacity, overflow, then free one slot and refill
    for (int i = 0; i < 14; i++) push(8'h10 + 8'(i));
    check_eq("fill14_wfull", 32'(wfull), 32'd0);
    push(8'h1E);
    check_eq("fill15_wfull", 32'(wfull), 32'd1);
    repeat (2) @(negedge rclk);
    check_eq("fill15_rfull", 32'(rfull), 32'd1);
    @(negedge wclk);
    wdata  = 8'hEE;
    wstore = 1'b1;
    #1;
    check_eq("ovf_flag", 32'(woverflow), 32'd1);
    @(negedge wclk);
    wstore = 1'b0;
    #1;
    check_eq("ovf_wfull",  32'(wfull),     32'd1);
    check_eq("ovf_clear",  32'(woverflow), 32'd0);
    pop_check("fill_0", 8'h10);
    n = 0;
    while (wfull && n < 10) begin
      @(negedge wclk);
      n++;
    end
    check_eq("space_wfull", 32'(wfull), 32'd0);
    push(8'h55);
    for (int i = 1; i < 15; i++) pop_check($sformatf("fill_%0d", i), 8'h10 + 8'(i));
    pop_check("fill_tail", 8'h55);
    check_eq("fill_rempty", 32'(rempty), 32'd1);
    repeat (3) @(negedge wclk);

    // 100-byte stream against random reads, wrapping the pointers several times
    sent  = 0;
    got_n = 0;
    exp_b = 8'h00;
    fork
      begin
        for (int c = 0; c < 20000 && sent < 100; c++) begin
          @(negedge wclk);
          if (!wfull) begin
            wdata  = 8'(sent);
            wstore = 1'b1;
            sent++;
          end else begin
            wstore = 1'b0;
          end
        end
        @(negedge wclk);
        wstore = 1'b0;
      end
      begin
        for (int c = 0; c < 3000 && got_n < 100; c++) begin
          @(negedge rclk);
          if (!rempty && ($urandom_range(0, 1) == 1)) begin
            check_eq($sformatf("stream_%0d", got_n), 32'(rdata), 32'(exp_b));
            exp_b = exp_b + 8'd1;
            got_n++;
            rread = 1'b1;
          end else begin
            rread = 1'b0;
          end
        end
        @(negedge rclk);
        rread = 1'b0;
      end
    join
    check_eq("stream_count", 32'(got_n), 32'd100);
    repeat (2) @(negedge rclk);
    check_eq("stream_rempty", 32'(rempty), 32'd1);

    // Reset mid-operation discards contents
    push(8'h11);
    push(8'h22);
    push(8'h33);
    reset_dut();
    check_eq("mrst_wempty", 32'(wempty), 32'd1);
    check_eq("mrst_rempty", 32'(rempty), 32'd1);
    check_eq("mrst_wfull",  32'(wfull),  32'd0);
    check_eq("mrst_rfull",  32'(rfull),  32'd0);
    push(8'h44);
    pop_check("mrst_next", 8'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
